cybernid_input_quantizer: RTL and testbench

Streaming input stage of the CyberNID LogicNet. It accepts raw signed feature samples one feature per beat and quantizes each to a 2-bit code using three programmable per-feature thresholds. It packs one full sample into a flat vector and presents it, with a valid/ready handshake, to the layer-0 neuron array, which consumes 2-bit fields combinationally.

---
 rtl/cybernid_input_quantizer.sv | 136 +++++++++++++
 tb/tb_cybernid_input_quantizer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cybernid_input_quantizer.sv
// Streaming input stage: quantizes signed feature beats to 2-bit codes and packs one sample.
// Latency: packed sample valid the cycle after the final beat; input stalls while output is pending.
module cybernid_input_quantizer #(
    parameter int NUM_FEATURES = 16,
    parameter int FEAT_W       = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [FEAT_W-1:0]                 s_data,
    input  logic                              s_last,
    input  logic                              cfg_we,
    input  logic [$clog2(NUM_FEATURES)+1:0]   cfg_addr,
    input  logic [FEAT_W-1:0]                 cfg_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [2*NUM_FEATURES-1:0]         m_data,
    output logic                              err_len
);

    localparam int            IW       = $clog2(NUM_FEATURES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_FEATURES - 1);
    localparam logic [IW:0]   NF_L     = (IW+1)'(NUM_FEATURES);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t                    state;
    logic [IW-1:0]             idx;
    logic signed [FEAT_W-1:0]  thr [NUM_FEATURES][3];
    logic [2*NUM_FEATURES-1:0] stage;
    logic [2*NUM_FEATURES-1:0] packed_next;

    logic signed [FEAT_W-1:0]  x;
    logic                      ge0, ge1, ge2;
    logic [1:0]                code;
    logic                      accept;

    logic [IW-1:0]             cfg_f;
    logic [1:0]                cfg_t;
    logic                      cfg_hit;

    assign x      = s_data;
    assign ge0    = (x >= thr[idx][0]);
    assign ge1    = (x >= thr[idx][1]);
    assign ge2    = (x >= thr[idx][2]);
    assign code   = {1'b0, ge0} + {1'b0, ge1} + {1'b0, ge2};
    assign accept = s_valid && s_ready;

    assign cfg_f   = cfg_addr[IW+1:2];
    assign cfg_t   = cfg_addr[1:0];
    assign cfg_hit = cfg_we && ({1'b0, cfg_f} < NF_L) && (cfg_t != 2'd3);

    assign m_valid = (state == OUTPUT);

    always_comb begin
        packed_next = stage;
        packed_next[2*(NUM_FEATURES-1) +: 2] = code;
    end

    // Quantization reads thr combinationally, so a same-cycle write is seen one beat later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_FEATURES; i++) begin
                for (int k = 0; k < 3; k++) begin
                    thr[i][k] <= '0;
                end
            end
        end else if (cfg_hit) begin
            thr[cfg_f][cfg_t] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= COLLECT;
            idx     <= '0;
            stage   <= '0;
            m_data  <= '0;
            err_len <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            err_len <= 1'b0;
            case (state)
                COLLECT: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        if (idx != LAST_IDX) begin
                            if (s_last) begin
                                err_len <= 1'b1;
                                stage   <= '0;
                                idx     <= '0;
                            end else begin
                                stage[{idx, 1'b0} +: 2] <= code;
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            idx   <= '0;
                            stage <= '0;
                            if (s_last) begin
                                m_data  <= packed_next;
                                state   <= OUTPUT;
                                s_ready <= 1'b0;
                            end else begin
                                err_len <= 1'b1;
                                state   <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    s_ready <= 1'b1;
                    if (accept && s_last) begin
                        state <= COLLECT;
                    end
                end
                OUTPUT: begin
                    s_ready <= 1'b0;
                    if (m_ready) begin
                        state   <= COLLECT;
                        s_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= COLLECT;
                    s_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cybernid_input_quantizer.sv
// Self-checking bench for cybernid_input_quantizer with three 16-bit features.
module tb_cybernid_input_quantizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        m_valid;
    logic        m_ready;
    logic [5:0]  m_data;
    logic        err_len;

    int n_cmp = 0;
    int n_err = 0;

    logic signed [15:0] tm [3][3];
    logic [5:0] sb [$];

    cybernid_input_quantizer #(.NUM_FEATURES(3), .FEAT_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .err_len(err_len)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] qz(input int f, input logic signed [15:0] xv);
        int s;
        s = 0;
        for (int k = 0; k < 3; k++) begin
            if (xv >= tm[f][k]) s++;
        end
        return s[1:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++)
                tm[i][k] = 16'sd0;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [15:0] d);
        if (a[1:0] != 2'd3 && a[3:2] < 2'd3) tm[a[3:2]][a[1:0]] = d;
    endtask

    task automatic wcfg(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        model_write(a, d);
    endtask

    task automatic beat(input logic [15:0] d, input logic l, input logic we,
                        input logic [3:0] a, input logic [15:0] cd,
                        output logic e, output logic mv, output int waits);
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = l;
        cfg_we = we; cfg_addr = a; cfg_data = cd;
        waits = 0;
        while (!s_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL beat_timeout: s_ready=%b required 1", s_ready);
        end
        @(posedge clk); #1;
        e = err_len; mv = m_valid;
        s_valid = 1'b0; s_last = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic consume(input string nm);
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        n_cmp++;
        if ({m_valid, s_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL %s_handshake: m_valid,s_ready=%b required 01", nm, {m_valid, s_ready});
        end
    endtask

    task automatic check_final(input string nm, input logic e, input logic mv);
        logic [5:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : 6'bxxxxxx;
        n_cmp++;
        if ({e, mv} !== 2'b01) begin
            n_err++;
            $display("FAIL %s_latency: err_len,m_valid=%b required 01", nm, {e, mv});
        end
        n_cmp++;
        if (m_data !== exp) begin
            n_err++;
            $display("FAIL %s_data: m_data=%b required %b", nm, m_data, exp);
        end
    endtask

    task automatic send3(input logic [15:0] v0, input logic [15:0] v1,
                         input logic [15:0] v2, input string nm);
        logic e, mv;
        int w;
        sb.push_back({qz(2, v2), qz(1, v1), qz(0, v0)});
        beat(v0, 1'b0, 1'b0, 4'd0, 16'd0, e, mv, w);
        n_cmp++;
        if ({e, mv} !== 2'b00) begin
            n_err++;
            $display("FAIL %s_beat0: err_len,m_valid=%b required 00", nm, {e, mv});
        end
        beat(v1, 1'b0, 1'b0, 4'd0, 16'd0, e, mv, w);
        n_cmp++;
        if ({e, mv} !== 2'b00) begin
            n_err++;
            $display("FAIL %s_beat1: err_len,m_valid=%b required 00", nm, {e, mv});
        end
        beat(v2, 1'b1, 1'b0, 4'd0, 16'd0, e, mv, w);
        check_final(nm, e, mv);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; m_ready = 1'b0;
        model_clear();
        #23;
        n_cmp++;
        if ({s_ready, m_valid, err_len, m_data} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_state: s_ready,m_valid,err_len,m_data=%b required 0", {s_ready, m_valid, err_len, m_data});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: s_ready=%b required 1", s_ready);
        end
    endtask

    task automatic test_nominal();
        for (int f = 0; f < 3; f++) begin
            wcfg({f[1:0], 2'd0}, -16'sd100);
            wcfg({f[1:0], 2'd1}, 16'sd0);
            wcfg({f[1:0], 2'd2}, 16'sd100);
        end
        send3(-16'sd200, 16'sd50, 16'sd100, "nominal");
        n_cmp++;
        if (m_data !== 6'b111000) begin
            n_err++;
            $display("FAIL nominal_const: m_data=%b required 111000", m_data);
        end
        consume("nominal");
    endtask

    task automatic test_backpressure();
        logic [5:0] held;
        logic e, mv;
        int w;
        send3(16'sd0, -16'sd100, 16'sd99, "bp");
        held = m_data;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({m_valid, s_ready, m_data} !== {2'b10, held}) begin
                n_err++;
                $display("FAIL bp_hold%0d: m_valid,s_ready,m_data=%b required %b", c, {m_valid, s_ready, m_data}, {2'b10, held});
            end
        end
        consume("bp");
        sb.push_back({qz(2, 16'sd200), qz(1, -16'sd1), qz(0, -16'sd50)});
        beat(-16'sd50, 1'b0, 1'b0, 4'd0, 16'd0, e, mv, w);
        n_cmp++;
        if (w !== 0) begin
            n_err++;
            $display("FAIL bp_next_accept: wait cycles=%0d required 0", w);
        end
        beat(-16'sd1, 1'b0, 1'b0, 4'd0, 16'd0, e, mv, w);
        beat(16'sd200, 1'b1, 1'b0, 4'd0, 16'd0, e, mv, w);
        check_final("bp_next", e, mv);
        consume("bp_next");
    endtask

    task automatic test_short();
        logic e, mv;
        int w;
        beat(16'sd5, 1'b0, 1'b0, 4'd0, 16'd0, e, mv, w);
        beat(16'sd5, 1'b1, 1'b0, 4'd0, 16'd0, e, mv, w);
        n_cmp++;
        if ({e, mv} !== 2'b10) begin
            n_err++;
            $display("FAIL short_err: err_len,m_valid=%b required 10", {e, mv});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({err_len, m_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL short_pulse: err_len,m_valid=%b required 00", {err_len, m_valid});
        end
        send3(16'sd1, -16'sd101, 16'sd100, "short_after");
        consume("short_after");
    endtask

    task automatic test_long();
        logic e, mv;
        int w;
        beat(16'sd1, 1'b0, 1'b0, 4'd0, 16'd0, e, mv, w);
        beat(16'sd2, 1'b0, 1'b0, 4'd0, 16'd0, e, mv, w);
        beat(16'sd3, 1'b0, 1'b0, 4'd0, 16'd0, e, mv, w);
        n_cmp++;
        if ({e, mv} !== 2'b10) begin
            n_err++;
            $display("FAIL long_err: err_len,m_valid=%b required 10", {e, mv});
        end
        beat(16'sd4, 1'b1, 1'b0, 4'd0, 16'd0, e, mv, w);
        n_cmp++;
        if ({e, mv} !== 2'b00) begin
            n_err++;
            $display("FAIL long_drain: err_len,m_valid=%b required 00", {e, mv});
        end
        send3(-16'sd150, 16'sd150, -16'sd99, "long_after");
        consume("long_after");
    endtask

    task automatic test_cfg_boundary();
        logic e, mv;
        int w;
        logic [1:0] c1;
        // Feature-1 beat and its threshold write land on the same edge.
        c1 = qz(1, 16'sd50);
        sb.push_back({qz(2, -16'sd101), c1, qz(0, 16'sd0)});
        beat(16'sd0, 1'b0, 1'b0, 4'd0, 16'd0, e, mv, w);
        beat(16'sd50, 1'b0, 1'b1, 4'b0110, 16'sd50, e, mv, w);
        model_write(4'b0110, 16'sd50);
        beat(-16'sd101, 1'b1, 1'b0, 4'd0, 16'd0, e, mv, w);
        check_final("cfg_same", e, mv);
        n_cmp++;
        if (m_data[3:2] !== 2'd2) begin
            n_err++;
            $display("FAIL cfg_old_thr: code=%0d required 2", m_data[3:2]);
        end
        consume("cfg_same");
        send3(16'sd0, 16'sd50, -16'sd101, "cfg_new");
        n_cmp++;
        if (m_data[3:2] !== 2'd3) begin
            n_err++;
            $display("FAIL cfg_new_thr: code=%0d required 3", m_data[3:2]);
        end
        consume("cfg_new");
        wcfg(4'b0111, 16'h7fff);
        wcfg(4'b0011, 16'h7fff);
        wcfg(4'b1100, 16'h7fff);
        wcfg(4'b1101, 16'h7fff);
        send3(16'sd50, 16'sd50, 16'sd50, "cfg_ignored");
        consume("cfg_ignored");
    endtask

    task automatic test_async_reset();
        logic e, mv;
        int w;
        sb.push_back({qz(2, 16'sd7), qz(1, 16'sd7), qz(0, 16'sd7)});
        beat(16'sd7, 1'b0, 1'b0, 4'd0, 16'd0, e, mv, w);
        beat(16'sd7, 1'b0, 1'b0, 4'd0, 16'd0, e, mv, w);
        beat(16'sd7, 1'b1, 1'b0, 4'd0, 16'd0, e, mv, w);
        check_final("pre_reset", e, mv);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({m_valid, m_data} !== 7'd0) begin
            n_err++;
            $display("FAIL async_reset: m_valid,m_data=%b required 0", {m_valid, m_data});
        end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        send3(16'sd5, -16'sd5, 16'sd0, "post_reset");
        n_cmp++;
        if (m_data !== 6'b110011) begin
            n_err++;
            $display("FAIL post_reset_const: m_data=%b required 110011", m_data);
        end
        consume("post_reset");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_short();
        test_long();
        test_cfg_boundary();
        test_async_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: %0d left required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
